// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - staged board-level reset manager with sticky reset cause
//
// Purpose:
//   Sits between the PLL and the SoC/device slaves. It synchronises the
//   external reset and the PLL lock indication, then qualifies lock for
//   LOCK_STABLE_CYCLES. After that it releases N_DOMAINS resets one at a time
//   in index order. Lock loss, a software request or a watchdog timeout put
//   every domain back into reset for SW_RST_HOLD cycles. After the hold, lock
//   is qualified again before the next release. cause_o records what caused
//   the last reset(s) until software clears it.
//
// Optional feature:
//   RSTSEQ_WDT_EN - when defined, adds a watchdog that counts RUN cycles
//   between kicks and forces a reset after WDT_TIMEOUT cycles.
//
// Ports:
//   clk             in   single clock (PLL output)
//   rstn            in   asynchronous active-low reset
//   pll_locked_i    in   PLL lock, asynchronous to clk
//   sw_reset_req_i  in   1-cycle software full-reset request
//   wdt_kick_i      in   1-cycle watchdog kick (ignored without RSTSEQ_WDT_EN)
//   cause_clr_i     in   1-cycle pulse clearing cause_o
//   domain_rstn_o   out  per-domain active-low resets, bit k released k-th
//   all_released_o  out  high only in RUN
//   cause_o         out  sticky cause {wdt, sw, lock_loss, ext}

module reset_sequencer #(
  parameter int SYNC_STAGES        = 3,
  parameter int N_DOMAINS          = 2,
  parameter int LOCK_STABLE_CYCLES = 256,
  parameter int STAGE_DELAY        = 16,
  parameter int SW_RST_HOLD        = 64,
  parameter int WDT_TIMEOUT        = 2**20
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 pll_locked_i,
  input  logic                 sw_reset_req_i,
  input  logic                 wdt_kick_i,
  input  logic                 cause_clr_i,
  output logic [N_DOMAINS-1:0] domain_rstn_o,
  output logic                 all_released_o,
  output logic [3:0]           cause_o
);

  localparam int LW = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int RW = $clog2(N_DOMAINS * STAGE_DELAY + 1);
  localparam int HW = $clog2(SW_RST_HOLD + 1);

  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [RW-1:0] REL_LAST  = RW'(N_DOMAINS * STAGE_DELAY);
  localparam logic [HW-1:0] HOLD_LAST = HW'(SW_RST_HOLD - 1);

  typedef enum logic [2:0] {
    S_RESET,
    S_WAIT_LOCK,
    S_RELEASE,
    S_RUN,
    S_HOLD
  } state_t;

  logic [SYNC_STAGES-1:0] r_rst_sync;
  logic [SYNC_STAGES-1:0] r_lock_sync;
  state_t                 r_state;
  logic [LW-1:0]          r_lock_cnt;
  logic [RW-1:0]          r_rel_cnt;
  logic [HW-1:0]          r_hold_cnt;
  logic [N_DOMAINS-1:0]   r_dom_rstn;
  logic                   r_all_rel;
  logic [3:0]             r_cause;

  logic                   w_rst_done;
  logic                   w_locked_s;
  state_t                 w_state_nxt;
  logic [LW-1:0]          w_lock_cnt_nxt;
  logic [RW-1:0]          w_rel_cnt_nxt;
  logic [RW-1:0]          w_rel_inc;
  logic [HW-1:0]          w_hold_cnt_nxt;
  logic [N_DOMAINS-1:0]   w_dom_nxt;
  logic                   w_all_nxt;
  logic [3:0]             w_cause_nxt;
  logic [3:0]             w_cause_set;
  logic                   w_ev_lock;
  logic                   w_ev_sw;
  logic                   w_ev_wdt;
  logic                   w_active;
  logic                   w_enter_hold;

  // Both chains clear on rstn, so locked_s is also forced low during reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rst_sync  <= '0;
      r_lock_sync <= '0;
    end else begin
      r_rst_sync  <= {r_rst_sync[SYNC_STAGES-2:0], 1'b1};
      r_lock_sync <= {r_lock_sync[SYNC_STAGES-2:0], pll_locked_i};
    end
  end

  assign w_rst_done = r_rst_sync[SYNC_STAGES-1];
  assign w_locked_s = r_lock_sync[SYNC_STAGES-1];
  assign w_rel_inc  = r_rel_cnt + RW'(1);

  // States that can be kicked into HOLD; HOLD itself only records new causes.
  assign w_active     = (r_state == S_WAIT_LOCK) || (r_state == S_RELEASE) || (r_state == S_RUN);
  assign w_ev_lock    = ((r_state == S_RELEASE) || (r_state == S_RUN)) && !w_locked_s;
  assign w_ev_sw      = sw_reset_req_i && (w_active || (r_state == S_HOLD));
  assign w_enter_hold = w_active && (w_ev_lock || w_ev_sw || w_ev_wdt);
  assign w_cause_set  = {w_ev_wdt, w_ev_sw, w_ev_lock, 1'b0};

`ifdef RSTSEQ_WDT_EN
  localparam int WW = $clog2(WDT_TIMEOUT + 1);
  localparam logic [WW-1:0] WDT_LAST = WW'(WDT_TIMEOUT - 1);

  logic [WW-1:0] r_wdt_cnt;

  // Expires on the edge where the count would reach WDT_TIMEOUT.
  assign w_ev_wdt = (r_state == S_RUN) && !wdt_kick_i && (r_wdt_cnt == WDT_LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wdt_cnt <= '0;
    end else if ((r_state == S_RUN) && (w_state_nxt == S_RUN) && !wdt_kick_i) begin
      r_wdt_cnt <= r_wdt_cnt + WW'(1);
    end else begin
      r_wdt_cnt <= '0;
    end
  end
`else
  logic w_unused_wdt;

  assign w_ev_wdt     = 1'b0;
  assign w_unused_wdt = &{1'b0, wdt_kick_i, (WDT_TIMEOUT > 0)};
`endif

  always_comb begin
    w_state_nxt    = r_state;
    w_lock_cnt_nxt = '0;
    w_rel_cnt_nxt  = '0;
    w_hold_cnt_nxt = '0;
    w_dom_nxt      = '0;
    w_all_nxt      = 1'b0;
    w_cause_nxt    = cause_clr_i ? w_cause_set : (r_cause | w_cause_set);

    case (r_state)
      S_RESET: begin
        if (w_rst_done) w_state_nxt = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (w_enter_hold) begin
          w_state_nxt = S_HOLD;
        end else if (w_locked_s) begin
          if (r_lock_cnt == LOCK_LAST) w_state_nxt = S_RELEASE;
          else                         w_lock_cnt_nxt = r_lock_cnt + LW'(1);
        end
      end
      S_RELEASE: begin
        if (w_enter_hold) begin
          w_state_nxt = S_HOLD;
        end else begin
          w_rel_cnt_nxt = w_rel_inc;
          // Domain k releases on the edge where the count reaches (k+1)*STAGE_DELAY.
          for (int k = 0; k < N_DOMAINS; k++) begin
            w_dom_nxt[k] = (w_rel_inc >= RW'((k + 1) * STAGE_DELAY));
          end
          if (w_rel_inc == REL_LAST) begin
            w_state_nxt   = S_RUN;
            w_rel_cnt_nxt = '0;
            w_all_nxt     = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (w_enter_hold) begin
          w_state_nxt = S_HOLD;
        end else begin
          w_dom_nxt = '1;
          w_all_nxt = 1'b1;
        end
      end
      S_HOLD: begin
        if (r_hold_cnt == HOLD_LAST) w_state_nxt = S_WAIT_LOCK;
        else                         w_hold_cnt_nxt = r_hold_cnt + HW'(1);
      end
      default: begin
        w_state_nxt = S_RESET;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= S_RESET;
      r_lock_cnt <= '0;
      r_rel_cnt  <= '0;
      r_hold_cnt <= '0;
      r_dom_rstn <= '0;
      r_all_rel  <= 1'b0;
      r_cause    <= 4'b0001;
    end else begin
      r_state    <= w_state_nxt;
      r_lock_cnt <= w_lock_cnt_nxt;
      r_rel_cnt  <= w_rel_cnt_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
      r_dom_rstn <= w_dom_nxt;
      r_all_rel  <= w_all_nxt;
      r_cause    <= w_cause_nxt;
    end
  end

  assign domain_rstn_o  = r_dom_rstn;
  assign all_released_o = r_all_rel;
  assign cause_o        = r_cause;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - directed self-checking bench for reset_sequencer

module tb_reset_sequencer;

  logic       clk;
  logic       rstn;
  logic       pll_locked_i;
  logic       sw_reset_req_i;
  logic       wdt_kick_i;
  logic       cause_clr_i;
  logic [2:0] domain_rstn_o;
  logic       all_released_o;
  logic [3:0] cause_o;

  int n_vec = 0;
  int n_err = 0;

`ifdef RSTSEQ_WDT_EN
  localparam logic [3:0] C_PRE4 = 4'b1100;
`else
  localparam logic [3:0] C_PRE4 = 4'b0100;
`endif

  reset_sequencer #(
    .SYNC_STAGES        (3),
    .N_DOMAINS          (3),
    .LOCK_STABLE_CYCLES (8),
    .STAGE_DELAY        (4),
    .SW_RST_HOLD        (5),
    .WDT_TIMEOUT        (20)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .pll_locked_i   (pll_locked_i),
    .sw_reset_req_i (sw_reset_req_i),
    .wdt_kick_i     (wdt_kick_i),
    .cause_clr_i    (cause_clr_i),
    .domain_rstn_o  (domain_rstn_o),
    .all_released_o (all_released_o),
    .cause_o        (cause_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rstn           = 1'b0;
    pll_locked_i   = 1'b1;
    sw_reset_req_i = 1'b0;
    wdt_kick_i     = 1'b0;
    cause_clr_i    = 1'b0;

    // 1: power-up
    tick(5);
    check("rst_dom",   32'(domain_rstn_o),  32'b000);
    check("rst_all",   32'(all_released_o), 32'b0);
    check("rst_cause", 32'(cause_o),        32'b0001);
    rstn = 1'b1;
    tick(15);
    check("t1_e15_dom", 32'(domain_rstn_o), 32'b000);
    tick(1);
    check("t1_e16_dom", 32'(domain_rstn_o), 32'b001);
    tick(3);
    check("t1_e19_dom", 32'(domain_rstn_o), 32'b001);
    tick(1);
    check("t1_e20_dom", 32'(domain_rstn_o), 32'b011);
    tick(3);
    check("t1_e23_dom", 32'(domain_rstn_o),  32'b011);
    check("t1_e23_all", 32'(all_released_o), 32'b0);
    tick(1);
    check("t1_e24_dom",   32'(domain_rstn_o),  32'b111);
    check("t1_e24_all",   32'(all_released_o), 32'b1);
    check("t1_e24_cause", 32'(cause_o),        32'b0001);

    // 2: lock glitch in WAIT_LOCK
    rstn = 1'b0;
    tick(2);
    rstn = 1'b1;
    tick(6);
    pll_locked_i = 1'b0;
    tick(6);
    pll_locked_i = 1'b1;
    tick(4);
    check("t2_e16_dom", 32'(domain_rstn_o), 32'b000);
    tick(10);
    check("t2_e26_dom", 32'(domain_rstn_o), 32'b000);
    tick(1);
    check("t2_e27_dom",   32'(domain_rstn_o), 32'b001);
    check("t2_e27_cause", 32'(cause_o),       32'b0001);
    tick(8);
    check("t2_e35_dom", 32'(domain_rstn_o),  32'b111);
    check("t2_e35_all", 32'(all_released_o), 32'b1);

    // 3: clear cause then software reset
    cause_clr_i = 1'b1;
    tick(1);
    cause_clr_i = 1'b0;
    check("t3_clr_cause", 32'(cause_o), 32'b0000);
    sw_reset_req_i = 1'b1;
    tick(1);
    sw_reset_req_i = 1'b0;
    check("t3_h0_dom",   32'(domain_rstn_o),  32'b000);
    check("t3_h0_all",   32'(all_released_o), 32'b0);
    check("t3_h0_cause", 32'(cause_o),        32'b0100);
    tick(4);
    check("t3_h4_dom", 32'(domain_rstn_o), 32'b000);
    tick(12);
    check("t3_h16_dom", 32'(domain_rstn_o), 32'b000);
    tick(1);
    check("t3_h17_dom", 32'(domain_rstn_o), 32'b001);
    tick(8);
    check("t3_h25_dom",   32'(domain_rstn_o),  32'b111);
    check("t3_h25_all",   32'(all_released_o), 32'b1);
    check("t3_h25_cause", 32'(cause_o),        32'b0100);

    // 6: watchdog
`ifdef RSTSEQ_WDT_EN
    tick(19);
    check("t6_u19_dom", 32'(domain_rstn_o), 32'b111);
    tick(1);
    check("t6_u20_dom",   32'(domain_rstn_o), 32'b000);
    check("t6_u20_cause", 32'(cause_o),       32'b1100);
    tick(25);
    check("t6_u45_all", 32'(all_released_o), 32'b1);
`else
    tick(45);
    check("t6_nowdt_dom",   32'(domain_rstn_o), 32'b111);
    check("t6_nowdt_cause", 32'(cause_o),       32'b0100);
`endif
    for (int i = 0; i < 4; i++) begin
      tick(9);
      wdt_kick_i = 1'b1;
      tick(1);
      wdt_kick_i = 1'b0;
    end
    check("t6_kick_dom",   32'(domain_rstn_o),  32'b111);
    check("t6_kick_all",   32'(all_released_o), 32'b1);
    check("t6_kick_cause", 32'(cause_o),        32'(C_PRE4));

    // 4: lock loss in RUN
    pll_locked_i = 1'b0;
    tick(3);
    check("t4_l3_dom", 32'(domain_rstn_o), 32'b111);
    tick(1);
    check("t4_l4_dom",   32'(domain_rstn_o),  32'b000);
    check("t4_l4_all",   32'(all_released_o), 32'b0);
    check("t4_l4_cause", 32'(cause_o),        32'(C_PRE4 | 4'b0010));
    tick(10);
    sw_reset_req_i = 1'b1;
    cause_clr_i    = 1'b1;
    tick(1);
    sw_reset_req_i = 1'b0;
    cause_clr_i    = 1'b0;
    check("t4_clr_sw_cause", 32'(cause_o), 32'b0100);
    tick(10);
    check("t4_lowlock_dom", 32'(domain_rstn_o), 32'b000);
    pll_locked_i = 1'b1;
    tick(14);
    check("t4_m14_dom", 32'(domain_rstn_o), 32'b000);
    tick(1);
    check("t4_m15_dom", 32'(domain_rstn_o), 32'b001);

    // 5: rstn pulse mid-RELEASE
    tick(1);
    rstn = 1'b0;
    #1;
    check("t5_async_dom",   32'(domain_rstn_o),  32'b000);
    check("t5_async_all",   32'(all_released_o), 32'b0);
    check("t5_async_cause", 32'(cause_o),        32'b0001);
    tick(2);
    rstn = 1'b1;
    tick(15);
    check("t5_e15_dom", 32'(domain_rstn_o), 32'b000);
    tick(1);
    check("t5_e16_dom", 32'(domain_rstn_o), 32'b001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
